pwm_cmp_sched: RTL and testbench

Duty-cycle scheduler that sits between the host register interface and the `pwm` timebase/output-compare block and drives its `cmpA` input. Accepts a new target compare value over a valid/ready handshake, then slews the live compare toward it by at most `STEP` per PWM period. Updates happen only on period boundaries, so the output stage never sees a mid-period compare change. Also provides a clean enable/disable sequence that parks the compare at zero.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_slew_step.sv | 36 +++
 rtl/pwm_cmp_sched.sv | 104 ++++++++++
 tb/tb_pwm_cmp_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm timebase/compare block and its compare scheduler.
package pwm_pkg;

    localparam int unsigned       PWM_WIDTH   = 20;
    localparam logic [PWM_WIDTH-1:0] PWM_CMP_MAX = 20'h007F8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        RAMP = 2'd2,
        PARK = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step: moves cur toward tgt by at most step; done when tgt is within reach.
module pwm_slew_step
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] nxt,
    output logic             done
);

    logic [WIDTH:0] cur_x;
    logic [WIDTH:0] tgt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] diff;
    logic           up;

    always_comb begin
        cur_x  = {1'b0, cur};
        tgt_x  = {1'b0, tgt};
        step_x = {1'b0, step};
        up     = tgt_x > cur_x;
        diff   = up ? (tgt_x - cur_x) : (cur_x - tgt_x);
        done   = diff <= step_x;
        // When not done the distance exceeds step, so neither direction can wrap.
        if (done)
            nxt = tgt;
        else if (up)
            nxt = cur + step;
        else
            nxt = cur - step;
    end

endmodule

// File: rtl/pwm_cmp_sched.sv
// Compare scheduler: accepts a target compare and slews cmpA toward it once per PWM period.
module pwm_cmp_sched
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH   = PWM_WIDTH,
    parameter logic [WIDTH-1:0] STEP    = 'h40,
    parameter logic [WIDTH-1:0] CMP_MAX = 'h7F8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             prd_start,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] cmpA,
    output logic             busy,
    output logic             settled,
    output logic             ovr
);

    sched_state_t     state, state_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] cmp_n;
    logic             settled_n;
    logic             ovr_n;

    logic [WIDTH-1:0] slew_tgt;
    logic [WIDTH-1:0] slew_nxt;
    logic             slew_done;

    // PARK reuses the ramp stepper with a target of zero.
    assign slew_tgt = (state == PARK) ? '0 : tgt_q;

    pwm_slew_step #(.WIDTH(WIDTH)) u_step (
        .cur  (cmpA),
        .tgt  (slew_tgt),
        .step (STEP),
        .nxt  (slew_nxt),
        .done (slew_done)
    );

    assign tgt_ready = (state == IDLE) & enable;
    assign busy      = (state == RAMP) | (state == PARK);

    always_comb begin
        state_n   = state;
        tgt_n     = tgt_q;
        cmp_n     = cmpA;
        settled_n = 1'b0;
        ovr_n     = ovr;
        unique case (state)
            OFF: begin
                if (enable)
                    state_n = IDLE;
            end
            IDLE: begin
                if (!enable) begin
                    state_n = PARK;
                end else if (tgt_valid) begin
                    tgt_n   = (tgt_data > CMP_MAX) ? CMP_MAX : tgt_data;
                    ovr_n   = ovr | (tgt_data > CMP_MAX);
                    state_n = RAMP;
                end
            end
            RAMP: begin
                if (!enable) begin
                    state_n = PARK;
                end else if (prd_start) begin
                    cmp_n = slew_nxt;
                    if (slew_done) begin
                        settled_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            PARK: begin
                if (prd_start) begin
                    cmp_n = slew_nxt;
                    if (slew_done)
                        state_n = OFF;
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OFF;
            tgt_q   <= '0;
            cmpA    <= '0;
            settled <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            tgt_q   <= tgt_n;
            cmpA    <= cmp_n;
            settled <= settled_n;
            ovr     <= ovr_n;
        end
    end

endmodule

// File: tb/tb_pwm_cmp_sched.sv
// Randomized self-checking bench for pwm_cmp_sched against a period-level slew model.
module tb_pwm_cmp_sched;

    localparam int unsigned W       = 20;
    localparam int unsigned STEP    = 'h40;
    localparam int unsigned CMP_MAX = 'h7F8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          prd_start;
    logic          tgt_valid;
    logic [W-1:0]  tgt_data;
    logic          tgt_ready;
    logic [W-1:0]  cmpA;
    logic          busy;
    logic          settled;
    logic          ovr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: live compare value, latched target and sticky clamp flag.
    int unsigned m_cmp;
    int unsigned m_tgt;
    logic        m_ovr;

    pwm_cmp_sched #(.WIDTH(W), .STEP(20'h40), .CMP_MAX(20'h7F8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .prd_start (prd_start),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .cmpA      (cmpA),
        .busy      (busy),
        .settled   (settled),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        prd_start = 1'b1;
        tick();
        prd_start = 1'b0;
    endtask

    task automatic gap_cycles();
        int unsigned n;
        n = $urandom_range(1, 6);
        repeat (n) begin
            tick();
            n_checks++;
            if (cmpA !== W'(m_cmp) || settled !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_hold: cmpA=%h settled=%b, required cmpA=%h settled=0", cmpA, settled, m_cmp);
            end
        end
    endtask

    task automatic wait_ready();
        int unsigned budget;
        budget = 0;
        while (tgt_ready !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        n_checks++;
        if (tgt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: tgt_ready=%b, required 1 within 100 cycles", tgt_ready);
        end
    endtask

    task automatic model_accept(input int unsigned d);
        m_tgt = (d > CMP_MAX) ? CMP_MAX : d;
        if (d > CMP_MAX) m_ovr = 1'b1;
    endtask

    task automatic send(input int unsigned d);
        wait_ready();
        tgt_valid = 1'b1;
        tgt_data  = W'(d);
        tick();
        tgt_valid = 1'b0;
        model_accept(d);
        n_checks++;
        if (busy !== 1'b1 || tgt_ready !== 1'b0 || ovr !== m_ovr || cmpA !== W'(m_cmp)) begin
            n_fail++;
            $display("FAIL accept: busy=%b ready=%b ovr=%b cmpA=%h, required 1 0 %b %h",
                     busy, tgt_ready, ovr, cmpA, m_ovr, m_cmp);
        end
    endtask

    task automatic expect_ramp(input string tag);
        int unsigned start, diff, n, exp;
        start = m_cmp;
        diff  = (m_tgt > start) ? m_tgt - start : start - m_tgt;
        n     = (diff == 0) ? 1 : (diff + STEP - 1) / STEP;
        for (int unsigned k = 1; k <= n; k++) begin
            gap_cycles();
            strobe();
            if (k == n) exp = m_tgt;
            else if (m_tgt > start) exp = start + k * STEP;
            else exp = start - k * STEP;
            m_cmp = exp;
            n_checks++;
            if (cmpA !== W'(exp) || settled !== (k == n) || busy !== (k != n)) begin
                n_fail++;
                $display("FAIL %s step %0d: cmpA=%h settled=%b busy=%b, required %h %b %b",
                         tag, k, cmpA, settled, busy, exp, (k == n), (k != n));
            end
        end
        tick();
        n_checks++;
        if (settled !== 1'b0 || tgt_ready !== 1'b1 || cmpA !== W'(m_cmp)) begin
            n_fail++;
            $display("FAIL %s after: settled=%b ready=%b cmpA=%h, required 0 1 %h",
                     tag, settled, tgt_ready, cmpA, m_cmp);
        end
    endtask

    task automatic expect_park(input bit reenable);
        int unsigned start, n, exp;
        start = m_cmp;
        tick();
        n_checks++;
        if (busy !== 1'b1 || tgt_ready !== 1'b0 || cmpA !== W'(m_cmp)) begin
            n_fail++;
            $display("FAIL park_entry: busy=%b ready=%b cmpA=%h, required 1 0 %h", busy, tgt_ready, cmpA, m_cmp);
        end
        n = (start == 0) ? 1 : (start + STEP - 1) / STEP;
        for (int unsigned k = 1; k <= n; k++) begin
            if (reenable && k == 2) enable = 1'b1;
            gap_cycles();
            strobe();
            exp   = (k == n) ? 0 : start - k * STEP;
            m_cmp = exp;
            n_checks++;
            if (cmpA !== W'(exp) || settled !== 1'b0 || tgt_ready !== 1'b0 || busy !== (k != n)) begin
                n_fail++;
                $display("FAIL park step %0d: cmpA=%h settled=%b ready=%b busy=%b, required %h 0 0 %b",
                         k, cmpA, settled, tgt_ready, busy, exp, (k != n));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; prd_start = 1'b0; tgt_valid = 1'b1; tgt_data = 20'h00123;
        m_cmp = 0; m_tgt = 0; m_ovr = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (cmpA !== '0 || tgt_ready !== 1'b0 || busy !== 1'b0 || settled !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: cmpA=%h ready=%b busy=%b settled=%b ovr=%b, required all 0",
                     cmpA, tgt_ready, busy, settled, ovr);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (tgt_ready !== 1'b0 || busy !== 1'b0 || cmpA !== '0) begin
            n_fail++;
            $display("FAIL off_hold_valid: ready=%b busy=%b cmpA=%h, required 0 0 0", tgt_ready, busy, cmpA);
        end
        tgt_valid = 1'b0;
        enable = 1'b1;
        tick();
        n_checks++;
        if (tgt_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_idle: ready=%b busy=%b, required 1 0", tgt_ready, busy);
        end
    endtask

    task automatic test_ramp_basic();
        send('h100);
        expect_ramp("ramp_up");
        send('h0F0);
        expect_ramp("small_down");
    endtask

    task automatic test_ovr();
        send('hFFFFF);
        n_checks++;
        if (ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: ovr=%b, required 1", ovr);
        end
        expect_ramp("clamp_ramp");
        send('h300);
        expect_ramp("after_ovr");
        n_checks++;
        if (ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: ovr=%b, required 1", ovr);
        end
    endtask

    task automatic test_same_cycle();
        wait_ready();
        prd_start = 1'b1; tgt_valid = 1'b1; tgt_data = 20'h00380;
        tick();
        prd_start = 1'b0; tgt_valid = 1'b0;
        model_accept('h380);
        n_checks++;
        if (cmpA !== W'(m_cmp) || busy !== 1'b1 || settled !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle: cmpA=%h busy=%b settled=%b, required %h 1 0", cmpA, busy, settled, m_cmp);
        end
        expect_ramp("same_cycle_ramp");
    endtask

    task automatic test_equal_target();
        send(m_cmp);
        expect_ramp("equal_target");
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 6; i++) begin
            send($urandom_range(0, 'h8FF));
            expect_ramp("random");
        end
    endtask

    task automatic test_park();
        enable = 1'b0;
        expect_park(1'b0);
        enable = 1'b1;
        tick();
        n_checks++;
        if (tgt_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable: ready=%b busy=%b, required 1 0", tgt_ready, busy);
        end
        send('h100);
        for (int unsigned k = 1; k <= 3; k++) begin
            gap_cycles();
            strobe();
            m_cmp = k * STEP;
            n_checks++;
            if (cmpA !== W'(m_cmp) || settled !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_park %0d: cmpA=%h settled=%b, required %h 0", k, cmpA, settled, m_cmp);
            end
        end
        enable = 1'b0;
        expect_park(1'b1);
        tick();
        n_checks++;
        if (tgt_ready !== 1'b1 || busy !== 1'b0 || cmpA !== '0) begin
            n_fail++;
            $display("FAIL park_to_idle: ready=%b busy=%b cmpA=%h, required 1 0 0", tgt_ready, busy, cmpA);
        end
    endtask

    task automatic test_reset_mid_ramp();
        send('h200);
        gap_cycles();
        strobe();
        m_cmp = STEP;
        n_checks++;
        if (cmpA !== W'(m_cmp)) begin
            n_fail++;
            $display("FAIL mid_ramp: cmpA=%h, required %h", cmpA, m_cmp);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cmpA !== '0 || tgt_ready !== 1'b0 || busy !== 1'b0 || settled !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cmpA=%h ready=%b busy=%b settled=%b ovr=%b, required all 0",
                     cmpA, tgt_ready, busy, settled, ovr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_ovr();
        test_same_cycle();
        test_equal_target();
        test_random();
        test_park();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
